// File: rtl/fft_stride_detect_if.sv
// Avalon-ST source bus from the FFT IP core into the stride detector.
//   source_valid / source_ready : beat handshake
//   source_sop / source_eop     : frame delimiters
//   source_error                : FFT error code, nonzero = error
//   source_real / source_imag   : bin value, two's complement, DATA_W bits
//   source_exp                  : block exponent
// master = FFT side, slave = detector side.
interface fft_stride_detect_if #(
  parameter int DATA_W = 12
);
  logic              source_valid;
  logic              source_ready;
  logic              source_sop;
  logic              source_eop;
  logic [1:0]        source_error;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic [5:0]        source_exp;

  modport master (
    output source_valid, source_sop, source_eop, source_error,
           source_real, source_imag, source_exp,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_error,
           source_real, source_imag, source_exp,
    output source_ready
  );
endinterface

// File: rtl/fft_stride_detect.sv
// Per-frame scan of FFT output bins: finds the first bin above MIN_BIN whose
// L1 magnitude |re|+|im| exceeds THRESH, and the peak bin over the same range.
// The result is held until acknowledged; the FFT is stalled meanwhile.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   src           : Avalon-ST source bus from the FFT (slave modport)
//   result_valid  : result fields valid, held until result_ack
//   result_ack    : consumer takes the result
//   result_found  : some bin crossed THRESH
//   result_bin    : first qualifying bin (0 if none)
//   result_mag    : magnitude at result_bin (0 if none)
//   peak_bin      : bin of maximum magnitude above MIN_BIN
//   peak_mag      : that maximum
//   frame_err     : frame malformed or FFT error seen (sticky within a frame)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for sop; non-sop beats are dropped
// SCAN  | inside a frame, evaluating one bin per accepted beat
// DONE  | result held, source_ready low, waiting for result_ack
module fft_stride_detect #(
  parameter int DATA_W  = 12,
  parameter int FFT_LEN = 4096,
  parameter int BIN_W   = 12,
  parameter int MIN_BIN = 300,
  parameter int THRESH  = 38
) (
  input  logic                clk,
  input  logic                rst,
  fft_stride_detect_if.slave  src,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                result_found,
  output logic [BIN_W-1:0]    result_bin,
  output logic [DATA_W:0]     result_mag,
  output logic [BIN_W-1:0]    peak_bin,
  output logic [DATA_W:0]     peak_mag,
  output logic                frame_err
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
  localparam logic [31:0]      MIN_U    = MIN_BIN;
  localparam logic [31:0]      THRESH_U = THRESH;

  state_t            state, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              found_d, err_d;
  logic [BIN_W-1:0]  res_bin_d, pk_bin_d;
  logic [DATA_W:0]   res_mag_d, pk_mag_d;

  logic              ready;
  logic              accept;
  logic              restart;
  logic [BIN_W-1:0]  idx;
  logic [DATA_W:0]   abs_re, abs_im, mag;
  logic              base_found, base_err;
  logic [BIN_W-1:0]  base_bin, base_pbin;
  logic [DATA_W:0]   base_mag, base_pmag;
  logic              in_range, hit, last_bin, frame_end, bad_len;

  // The block exponent carries no information for a threshold on raw bins.
  logic [5:0]        unused_exp;
  assign unused_exp = src.source_exp;

  // Sign-extend one bit first so that the most negative input maps to a
  // positive value instead of wrapping.
  function automatic logic [DATA_W:0] abs_ext(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    return v[DATA_W-1] ? (~ext + (DATA_W+1)'(1)) : ext;
  endfunction

  assign abs_re = abs_ext(src.source_real);
  assign abs_im = abs_ext(src.source_imag);
  assign mag    = abs_re + abs_im;

  assign ready            = (state != DONE);
  assign src.source_ready = ready;
  assign result_valid     = (state == DONE);
  assign accept           = src.source_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bin_q        <= '0;
      result_found <= 1'b0;
      result_bin   <= '0;
      result_mag   <= '0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_d;
      bin_q        <= bin_d;
      result_found <= found_d;
      result_bin   <= res_bin_d;
      result_mag   <= res_mag_d;
      peak_bin     <= pk_bin_d;
      peak_mag     <= pk_mag_d;
      frame_err    <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    bin_d     = bin_q;
    found_d   = result_found;
    res_bin_d = result_bin;
    res_mag_d = result_mag;
    pk_bin_d  = peak_bin;
    pk_mag_d  = peak_mag;
    err_d     = frame_err;

    // A sop starts a fresh frame at bin 0 with cleared working registers.
    // A sop arriving mid-frame also marks the frame as malformed.
    restart    = accept && src.source_sop;
    idx        = restart ? '0 : bin_q + BIN_W'(1);
    base_found = restart ? 1'b0 : result_found;
    base_bin   = restart ? '0   : result_bin;
    base_mag   = restart ? '0   : result_mag;
    base_pbin  = restart ? '0   : peak_bin;
    base_pmag  = restart ? '0   : peak_mag;
    base_err   = restart ? (state == SCAN) : frame_err;

    in_range  = 32'(idx) > MIN_U;
    hit       = in_range && (32'(mag) > THRESH_U) && !base_found;
    last_bin  = (idx == LAST_BIN);
    // The frame ends on eop or on the last bin, whichever comes first;
    // either one without the other means the frame length was wrong.
    frame_end = src.source_eop || last_bin;
    bad_len   = src.source_eop != last_bin;

    case (state)
      IDLE, SCAN: begin
        if ((state == IDLE && restart) || (state == SCAN && accept)) begin
          bin_d     = idx;
          found_d   = base_found | hit;
          res_bin_d = hit ? idx : base_bin;
          res_mag_d = hit ? mag : base_mag;
          if (in_range && (mag > base_pmag)) begin
            pk_bin_d = idx;
            pk_mag_d = mag;
          end else begin
            pk_bin_d = base_pbin;
            pk_mag_d = base_pmag;
          end
          err_d   = base_err | (|src.source_error) | bad_len;
          state_d = frame_end ? DONE : SCAN;
        end
      end
      DONE: begin
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_stride_detect.sv
module tb_fft_stride_detect;
  localparam int DATA_W  = 12;
  localparam int FFT_LEN = 4096;
  localparam int BIN_W   = 12;
  localparam int MIN_BIN = 300;
  localparam int THRESH  = 38;
  localparam int NV      = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stride_detect_if #(.DATA_W(DATA_W)) src_if ();

  logic              result_valid, result_ack, result_found, frame_err;
  logic [BIN_W-1:0]  result_bin, peak_bin;
  logic [DATA_W:0]   result_mag, peak_mag;

  fft_stride_detect #(
    .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .BIN_W(BIN_W),
    .MIN_BIN(MIN_BIN), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .src(src_if.slave),
    .result_valid(result_valid), .result_ack(result_ack),
    .result_found(result_found), .result_bin(result_bin),
    .result_mag(result_mag), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .frame_err(frame_err)
  );

  typedef struct {
    int len; bit has_eop; int restart_at; int err_at;
    bit e_found; int e_bin; int e_mag; int e_pbin; int e_pmag; bit e_err;
  } vec_t;

  typedef struct {
    bit found; int bin; int mag; int pbin; int pmag; bit err;
  } exp_t;

  vec_t vecs[NV];
  int   sp_idx[NV][4];
  int   sp_re[NV][4];
  int   sp_im[NV][4];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int n, input int len, input bit eop, input int rs, input int ea,
                         input bit f, input int b, input int m, input int pb, input int pm,
                         input bit e);
    vecs[n].len = len; vecs[n].has_eop = eop; vecs[n].restart_at = rs; vecs[n].err_at = ea;
    vecs[n].e_found = f; vecs[n].e_bin = b; vecs[n].e_mag = m;
    vecs[n].e_pbin = pb; vecs[n].e_pmag = pm; vecs[n].e_err = e;
    for (int k = 0; k < 4; k++) begin
      sp_idx[n][k] = -1; sp_re[n][k] = 0; sp_im[n][k] = 0;
    end
  endtask

  task automatic set_sp(input int n, input int k, input int idx, input int re, input int im);
    sp_idx[n][k] = idx; sp_re[n][k] = re; sp_im[n][k] = im;
  endtask

  function automatic int beat_re(input int n, input int b);
    for (int k = 0; k < 4; k++) if (sp_idx[n][k] == b) return sp_re[n][k];
    return 0;
  endfunction

  function automatic int beat_im(input int n, input int b);
    for (int k = 0; k < 4; k++) if (sp_idx[n][k] == b) return sp_im[n][k];
    return 0;
  endfunction

  task automatic idle_bus(input bit hold);
    src_if.source_valid = hold;
    src_if.source_sop   = 1'b0;
    src_if.source_eop   = 1'b0;
    src_if.source_error = 2'b00;
    src_if.source_real  = '0;
    src_if.source_imag  = '0;
    src_if.source_exp   = '0;
  endtask

  // Drives one beat per cycle; returns at the negedge after the last beat.
  task automatic drive_beats(input int n, input int count, input bit hold);
    for (int b = 0; b < count; b++) begin
      @(negedge clk);
      src_if.source_valid = 1'b1;
      src_if.source_sop   = (b == 0) || (b == vecs[n].restart_at);
      src_if.source_eop   = vecs[n].has_eop && (b == vecs[n].len - 1);
      src_if.source_error = (b == vecs[n].err_at) ? 2'b01 : 2'b00;
      src_if.source_real  = DATA_W'(beat_re(n, b));
      src_if.source_imag  = DATA_W'(beat_im(n, b));
      src_if.source_exp   = 6'(b);
    end
    @(negedge clk);
    idle_bus(hold);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int waited;
    waited = 0;
    check({tag, "_latency"}, int'(result_valid), 1);
    while (!result_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: result_valid still 0 after %0d cycles", tag, waited);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: result with no expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_found"},    int'(result_found), int'(e.found));
    check({tag, "_bin"},      int'(result_bin),   e.bin);
    check({tag, "_mag"},      int'(result_mag),   e.mag);
    check({tag, "_peak_bin"}, int'(peak_bin),     e.pbin);
    check({tag, "_peak_mag"}, int'(peak_mag),     e.pmag);
    check({tag, "_err"},      int'(frame_err),    int'(e.err));
    check({tag, "_ready"},    int'(src_if.source_ready), 0);
  endtask

  task automatic run_frame(input int n, input bit hold, input string tag);
    exp_t e;
    e.found = vecs[n].e_found; e.bin = vecs[n].e_bin; e.mag = vecs[n].e_mag;
    e.pbin = vecs[n].e_pbin; e.pmag = vecs[n].e_pmag; e.err = vecs[n].e_err;
    sb_q.push_back(e);
    drive_beats(n, vecs[n].len, hold);
    collect(tag);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check({tag, "_ack_valid"}, int'(result_valid), 0);
    check({tag, "_ack_ready"}, int'(src_if.source_ready), 1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"},    int'(result_valid), 0);
    check({tag, "_ready"},    int'(src_if.source_ready), 1);
    check({tag, "_found"},    int'(result_found), 0);
    check({tag, "_bin"},      int'(result_bin), 0);
    check({tag, "_mag"},      int'(result_mag), 0);
    check({tag, "_peak_bin"}, int'(peak_bin), 0);
    check({tag, "_peak_mag"}, int'(peak_mag), 0);
    check({tag, "_err"},      int'(frame_err), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // n, len, eop, restart_at, err_at, found, bin, mag, peak_bin, peak_mag, err
    set_vec(0, 4096, 1, -1, -1, 1, 512, 39, 512, 39, 0);
    set_sp (0, 0, 512, 20, -19);
    set_vec(1, 4096, 1, -1, -1, 1, 302, 39, 900, 200, 0);
    set_sp (1, 0, 300, 100, 0);
    set_sp (1, 1, 301, 38, 0);
    set_sp (1, 2, 302, 0, 39);
    set_sp (1, 3, 900, -200, 0);
    set_vec(2, 4096, 1, -1, -1, 1, 1000, 4096, 1000, 4096, 0);
    set_sp (2, 0, 1000, -2048, -2048);
    set_sp (2, 1, 2000, -2048, -2048);
    set_vec(3, 101, 1, -1, -1, 0, 0, 0, 0, 0, 1);
    set_sp (3, 0, 50, 50, 0);
    set_sp (3, 1, 100, -60, 0);
    set_vec(4, 4796, 1, 700, -1, 1, 400, 60, 400, 60, 1);
    set_sp (4, 0, 200, 60, 0);
    set_sp (4, 1, 350, 0, 100);
    set_sp (4, 2, 1100, 30, -30);
    set_vec(5, 4096, 1, -1, 10, 1, 3000, 55, 3000, 55, 1);
    set_sp (5, 0, 3000, -5, 50);
    set_vec(6, 4096, 0, -1, -1, 1, 4095, 41, 4095, 41, 1);
    set_sp (6, 0, 4095, 1, 40);
    set_vec(7, 4096, 1, -1, -1, 0, 0, 0, 800, 30, 0);
    set_sp (7, 0, 800, 15, -15);
    set_sp (7, 1, 290, 0, 500);

    idle_bus(1'b0);
    result_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    for (int n = 0; n < NV; n++) begin
      run_frame(n, 1'b0, $sformatf("vec%0d", n));
      do_ack($sformatf("vec%0d", n));
    end

    // Backpressure: valid held high while the result waits 50 cycles.
    run_frame(0, 1'b1, "bp");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_if.source_ready !== 1'b0 || result_valid !== 1'b1 ||
          result_found !== 1'b1 || int'(result_bin) != 512 || int'(result_mag) != 39 ||
          int'(peak_bin) != 512 || int'(peak_mag) != 39 || frame_err !== 1'b0)
        bad++;
    end
    check("bp_stable_violations", bad, 0);
    do_ack("bp");
    run_frame(7, 1'b0, "bp_next");
    do_ack("bp_next");

    // Reset in the middle of a frame, after a hit at bin 512.
    drive_beats(0, 2001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("rst_mid");
    run_frame(1, 1'b0, "after_rst");
    do_ack("after_rst");

    // Reset while a result is pending.
    run_frame(2, 1'b0, "pre_rst_done");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("rst_done");
    run_frame(5, 1'b0, "after_rst_done");
    do_ack("after_rst_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_stride_detect.md
Name: fft_stride_detect

Overview:
- Downstream consumer of the FFT IP source (Avalon-ST) port.
- Per FFT frame, computes the L1 magnitude |re|+|im| of each bin.
- Reports the first bin above MIN_BIN whose magnitude exceeds THRESH (image stride/height), plus the peak bin over the same range.
- Holds the result until acknowledged, back-pressuring the FFT through source_ready meanwhile.

Parameters:
DATA_W, 12, width of source_real/source_imag (two's complement)
FFT_LEN, 4096, transform length (power of 2)
BIN_W, 12, log2(FFT_LEN)
MIN_BIN, 300, bins with index <= MIN_BIN are excluded from detection and peak search
THRESH, 38, detection threshold; a bin qualifies when magnitude is strictly greater

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
source_valid  in  1  FFT output beat valid
source_ready  out  1  this block accepts a beat
source_sop  in  1  first bin of frame
source_eop  in  1  last bin of frame
source_error  in  2  FFT error code, nonzero = error
source_real  in  DATA_W  bin real part
source_imag  in  DATA_W  bin imaginary part
source_exp  in  6  block exponent (ignored; frame_err not affected)
result_valid  out  1  result fields valid, held until ack
result_ack  in  1  consumer accepts result
result_found  out  1  a bin crossed THRESH
result_bin  out  BIN_W  first qualifying bin index (0 if none)
result_mag  out  DATA_W+1  magnitude at result_bin (0 if none)
peak_bin  out  BIN_W  bin of maximum magnitude, index > MIN_BIN
peak_mag  out  DATA_W+1  that maximum
frame_err  out  1  frame malformed or FFT error seen

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Beat acceptance: a beat is accepted when source_valid && source_ready.
- Magnitude: abs of each component is computed in DATA_W+1 bits, so -2048 yields 2048. The sum is DATA_W+1 bits and cannot overflow (max 4096 at DATA_W=12).
- States:
  - IDLE: source_ready=1. Accepted beats without sop are discarded. An accepted sop beat sets bin=0, clears working registers, evaluates that beat as bin 0, and moves to SCAN.
  - SCAN: source_ready=1. Each accepted beat increments bin.
    - Detection fires when bin > MIN_BIN, mag > THRESH, and nothing has been found yet. It latches the bin and its magnitude; only the first hit is kept.
    - Peak tracking: for bin > MIN_BIN, update peak when mag > peak_mag (strict), so ties keep the earliest bin.
    - An accepted eop beat is evaluated first, then the block moves to DONE.
  - DONE: source_ready=0 and result_valid=1, with all outputs stable. result_ack moves to IDLE the next cycle; result_valid drops and source_ready rises that same cycle. result_ack outside DONE is ignored.
- Latency: result_valid is high the cycle after the eop beat is accepted.
- Error handling:
  - sop accepted in SCAN: discard the partial frame, set the sticky frame_err, and restart at bin 0 with that beat.
  - eop with bin != FFT_LEN-1: frame_err=1; still go to DONE.
  - bin reaches FFT_LEN-1 without eop: frame_err=1; treat as end of frame and go to DONE.
  - Any accepted beat with source_error != 0: frame_err=1.
  - frame_err clears only on a new frame start from IDLE.
- Degenerate case: MIN_BIN >= FFT_LEN-1 means no bins qualify, so found=0, peak_bin=0, peak_mag=0.
- Reset values: result_valid=0, result_found=0, result_bin=0, result_mag=0, peak_bin=0, peak_mag=0, frame_err=0, source_ready=1, state=IDLE.
- Reset mid-frame or while in DONE: the pending result is lost and the block returns to IDLE.

Test Plan:
- 4096-beat frame, all zero except bin 512 (re=20, im=-19, mag 39) → result_valid 1 cycle after eop, found=1, bin=512, mag=39, peak_bin=512, frame_err=0.
- Boundary frame: bin 300 mag 100, bin 301 mag 38, bin 302 mag 39, bin 900 mag 200 → result_bin=302, result_mag=39, peak_bin=900, peak_mag=200.
- Sign edge and tie frame: bin 1000 re=-2048 im=-2048, plus bin 2000 with equal mag 4096 → peak_mag=4096, peak_bin=1000, result_bin=1000.
- Backpressure: hold result_ack=0 for 50 cycles after eop while driving source_valid=1 → source_ready=0 and outputs stable; assert ack → next cycle result_valid=0, source_ready=1, and a new frame is accepted.
- Malformed frames: eop at bin 100 → frame_err=1, found=0. Second sop at bin 700 → frame restarts and result indices are relative to the new sop. source_error=2'b01 on one beat → frame_err=1.
- Reset: assert rst at bin 2000 mid-frame → all outputs 0, state IDLE; a following clean frame gives the correct result.
